// File: rtl/mem_bus_responder_if.sv
// Bus bundle between the multiplexed core bus, the responder and the memory.
// The slave modport is the responder's view; the master modport is the
// view of whatever drives the core bus and models the memory.
interface mem_bus_responder_if #(
  parameter int OVR_CNT_W = 8
);
  // core side
  logic [7:0]           bus_ab;
  logic [7:0]           bus_d;
  logic [7:0]           bus_q;
  logic                 phase;
  // memory side
  logic                 mem_req;
  logic                 mem_we;
  logic [15:0]          mem_addr;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rdata;
  logic                 mem_ack;
  // status
  logic                 overrun;
  logic [OVR_CNT_W-1:0] drop_cnt;

  modport slave (
    input  bus_ab, bus_d, mem_rdata, mem_ack,
    output bus_q, phase, mem_req, mem_we, mem_addr, mem_wdata, overrun, drop_cnt
  );

  modport master (
    output bus_ab, bus_d, mem_rdata, mem_ack,
    input  bus_q, phase, mem_req, mem_we, mem_addr, mem_wdata, overrun, drop_cnt
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory bus responder: assembles a two-phase multiplexed core frame
// (HI: address high + write data, LO: address low + rw) into a single
// memory request, returns read data on bus_q, and counts frames that
// arrive while a request is still outstanding.
module mem_bus_responder #(
  parameter int OVR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_bus_responder_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [7:0]           addr_hi_q, addr_hi_d;
  logic [7:0]           wdata_hold_q, wdata_hold_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [15:0]          mem_addr_q, mem_addr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic [7:0]           bus_q_q, bus_q_d;
  logic                 overrun_q, overrun_d;
  logic [OVR_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // A frame completes on every LO-phase edge; its low address byte and rw
  // bit are taken straight off the bus on that edge.
  logic        frame_done;
  logic [15:0] frame_addr;
  logic        frame_is_read;
  logic        ack_taken;
  logic        load_req;

  assign frame_done    = phase_q;
  assign frame_addr    = {addr_hi_q, bus.bus_ab};
  assign frame_is_read = bus.bus_d[0];
  assign ack_taken     = (state_q == BUSY) && bus.mem_ack;

  // Next-state and output computation: frame capture, FSM, read return, drops.
  always_comb begin
    state_d      = state_q;
    phase_d      = ~phase_q;
    addr_hi_d    = addr_hi_q;
    wdata_hold_d = wdata_hold_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    bus_q_d      = bus_q_q;
    overrun_d    = overrun_q;
    drop_cnt_d   = drop_cnt_q;
    load_req     = 1'b0;

    if (!phase_q) begin
      addr_hi_d    = bus.bus_ab;
      wdata_hold_d = bus.bus_d;
    end

    // Read data is returned only for an acknowledged outstanding read;
    // acks while idle are spurious and ignored.
    if (ack_taken && !mem_we_q) begin
      bus_q_d = bus.mem_rdata;
    end

    case (state_q)
      IDLE: begin
        if (frame_done) begin
          load_req = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          if (frame_done) begin
            // old request retires and the new frame takes its place
            load_req = 1'b1;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end else if (frame_done) begin
          // request still outstanding: drop the new frame
          overrun_d = 1'b1;
          if (drop_cnt_q != {OVR_CNT_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_req) begin
      mem_req_d   = 1'b1;
      mem_addr_d  = frame_addr;
      mem_we_d    = ~frame_is_read;
      mem_wdata_d = wdata_hold_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      addr_hi_q    <= '0;
      wdata_hold_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      bus_q_q      <= '0;
      overrun_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      addr_hi_q    <= addr_hi_d;
      wdata_hold_q <= wdata_hold_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      bus_q_q      <= bus_q_d;
      overrun_q    <= overrun_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.bus_q     = bus_q_q;
  assign bus.overrun   = overrun_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Testbench for mem_bus_responder: directed frames with literal expectations,
// then randomized traffic, all compared each cycle against a transaction model.
module tb_mem_bus_responder;
  localparam int W      = 8;
  localparam int CNTMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_bus_responder_if #(.OVR_CNT_W(W)) bif();

  mem_bus_responder #(.OVR_CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_valid = 1'b0;
  bit          m_phase;       // 0 = HI cycle, 1 = LO cycle
  logic [7:0]  m_hi, m_hold;  // partial frame from the HI cycle
  bit          m_busy;        // one request outstanding
  logic [15:0] m_addr;
  bit          m_we;
  logic [7:0]  m_wdata;
  logic [7:0]  m_q;
  bit          m_ovr;
  int          m_drops;       // unsaturated count of dropped frames

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (!rst_n) begin
      m_phase = 0; m_hi = '0; m_hold = '0; m_busy = 0; m_addr = '0;
      m_we = 0; m_wdata = '0; m_q = '0; m_ovr = 0; m_drops = 0;
    end else begin
      // retire the outstanding request first
      if (m_busy && bif.mem_ack) begin
        if (!m_we) m_q = bif.mem_rdata;
        m_busy = 0;
      end
      if (m_phase) begin
        // frame complete: accept if nothing outstanding, else drop it
        if (!m_busy) begin
          m_busy  = 1;
          m_addr  = {m_hi, bif.bus_ab};
          m_we    = ~bif.bus_d[0];
          m_wdata = m_hold;
        end else begin
          m_drops++;
          m_ovr = 1;
        end
      end else begin
        m_hi   = bif.bus_ab;
        m_hold = bif.bus_d;
      end
      m_phase = ~m_phase;
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("phase", bif.phase, m_phase);
      chk("mem_req", bif.mem_req, m_busy);
      if (m_busy) begin
        chk("mem_addr", bif.mem_addr, m_addr);
        chk("mem_we", bif.mem_we, m_we);
        if (m_we) chk("mem_wdata", bif.mem_wdata, m_wdata);
      end
      chk("bus_q", bif.bus_q, m_q);
      chk("overrun", bif.overrun, m_ovr);
      chk("drop_cnt", bif.drop_cnt, (m_drops > CNTMAX) ? CNTMAX : m_drops);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [7:0] ab, input logic [7:0] d,
                      input logic ack, input logic [7:0] rd);
    bif.bus_ab    = ab;
    bif.bus_d     = d;
    bif.mem_ack   = ack;
    bif.mem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"},     bif.phase,     0);
    chk({tag, "_mem_req"},   bif.mem_req,   0);
    chk({tag, "_mem_we"},    bif.mem_we,    0);
    chk({tag, "_mem_addr"},  bif.mem_addr,  0);
    chk({tag, "_mem_wdata"}, bif.mem_wdata, 0);
    chk({tag, "_bus_q"},     bif.bus_q,     0);
    chk({tag, "_overrun"},   bif.overrun,   0);
    chk({tag, "_drop_cnt"},  bif.drop_cnt,  0);
  endtask

  initial begin
    rst_n = 1'b0;
    bif.bus_ab = '0; bif.bus_d = '0; bif.mem_ack = 1'b0; bif.mem_rdata = '0;
    repeat (3) step(8'h00, 8'h00, 1'b0, 8'h00);
    chk_all_zero("reset");

    // Read, zero-wait: first cycle after release is HI
    rst_n = 1'b1;
    step(8'h12, 8'h00, 1'b0, 8'h00);
    step(8'h34, 8'h01, 1'b0, 8'h00);
    chk("rd_req", bif.mem_req, 1);
    chk("rd_addr", bif.mem_addr, 16'h1234);
    chk("rd_we", bif.mem_we, 0);
    // ack in first BUSY cycle; this HI cycle also starts the write frame
    step(8'h80, 8'h5C, 1'b1, 8'hA5);
    chk("rd_bus_q", bif.bus_q, 8'hA5);
    chk("rd_req_drop", bif.mem_req, 0);

    // Write; the ack in this idle LO cycle is spurious (rdata 0x77 ignored)
    step(8'h01, 8'h00, 1'b1, 8'h77);
    chk("spur_bus_q", bif.bus_q, 8'hA5);
    chk("wr_req", bif.mem_req, 1);
    chk("wr_addr", bif.mem_addr, 16'h8001);
    chk("wr_we", bif.mem_we, 1);
    chk("wr_wdata", bif.mem_wdata, 8'h5C);
    step(8'hAA, 8'h11, 1'b1, 8'h33);
    chk("wr_bus_q_hold", bif.bus_q, 8'hA5);
    chk("wr_req_drop", bif.mem_req, 0);

    // Stall: read to 0xAABB, ack withheld 5 cycles across two further frames
    step(8'hBB, 8'h01, 1'b0, 8'h00);
    step(8'hC1, 8'h00, 1'b0, 8'h00);
    step(8'hC2, 8'h01, 1'b0, 8'h00);
    step(8'hD1, 8'h00, 1'b0, 8'h00);
    step(8'hD2, 8'h01, 1'b0, 8'h00);
    step(8'hE1, 8'h00, 1'b0, 8'h00);
    chk("stall_addr", bif.mem_addr, 16'hAABB);
    chk("stall_req", bif.mem_req, 1);
    chk("stall_ovr", bif.overrun, 1);
    chk("stall_drops", bif.drop_cnt, 2);

    // Ack coincident with frame complete
    step(8'hE2, 8'h01, 1'b1, 8'h5A);
    chk("coin_bus_q", bif.bus_q, 8'h5A);
    chk("coin_req", bif.mem_req, 1);
    chk("coin_addr", bif.mem_addr, 16'hE1E2);
    chk("coin_drops", bif.drop_cnt, 2);
    step(8'hF0, 8'h00, 1'b1, 8'h99);
    chk("coin_ack_bus_q", bif.bus_q, 8'h99);
    chk("coin_idle", bif.mem_req, 0);

    // Saturation: hold a read outstanding across 260 more frames
    step(8'hF1, 8'h01, 1'b0, 8'h00);
    for (int i = 0; i < 520; i++)
      step(8'($urandom), 8'($urandom), 1'b0, 8'($urandom));
    chk("sat_drops", bif.drop_cnt, 8'hFF);
    chk("sat_req", bif.mem_req, 1);

    // Reset mid-BUSY with ack on the reset edge
    rst_n = 1'b0;
    step(8'($urandom), 8'($urandom), 1'b1, 8'hEE);
    chk_all_zero("rst_busy");
    step(8'h00, 8'h00, 1'b0, 8'h00);
    rst_n = 1'b1;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      step(8'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
